// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs. data with data priority, starvation guard and timeout.
// Optional ARB_PERF_CNT_EN adds saturating grant and wait-cycle counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm, StDone} state_e;

  state_e      state_q;
  logic [31:0] starve_cnt_q;
  logic [31:0] tmo_cnt_q;
  logic        grant_dm;
  logic        grant_if;
  logic        timeout_hit;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    grant_dm = dm_req && ((starve_cnt_q < STARVE_LIMIT) || !if_req);
    grant_if = !grant_dm && if_req;
  end

  // The current cycle is the TIMEOUT-th BUSY cycle without an ack.
  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
      if_valid     <= 1'b0;
      dm_valid     <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tmo_cnt_q <= '0;
          if (grant_dm) begin
            state_q <= StBusyDm;
            m_req   <= 1'b1;
            m_we    <= dm_we;
            m_addr  <= dm_addr;
            m_wdata <= dm_wdata;
            if (!if_req) begin
              starve_cnt_q <= '0;
            end else if (starve_cnt_q != STARVE_LIMIT) begin
              starve_cnt_q <= starve_cnt_q + 1;
            end
          end else if (grant_if) begin
            state_q      <= StBusyIf;
            m_req        <= 1'b1;
            m_we         <= 1'b0;
            m_addr       <= if_addr;
            m_wdata      <= '0;
            starve_cnt_q <= '0;
          end
        end
        StBusyIf, StBusyDm: begin
          // An ack in the timeout cycle still counts as success.
          if (m_ack) begin
            state_q  <= StDone;
            m_req    <= 1'b0;
            if_valid <= (state_q == StBusyIf);
            dm_valid <= (state_q == StBusyDm);
            if (state_q == StBusyIf) begin
              if_rdata <= m_rdata;
            end else if (!m_we) begin
              dm_rdata <= m_rdata;
            end
          end else if (timeout_hit) begin
            state_q  <= StDone;
            m_req    <= 1'b0;
            err      <= 1'b1;
            if_valid <= (state_q == StBusyIf);
            dm_valid <= (state_q == StBusyDm);
            if (state_q == StBusyIf) begin
              if_rdata <= '0;
            end else begin
              dm_rdata <= '0;
            end
          end else if (TIMEOUT != 0) begin
            tmo_cnt_q <= tmo_cnt_q + 1;
          end
        end
        StDone: begin
          state_q  <= StIdle;
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          err      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_grants   <= '0;
      perf_dm_grants   <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (state_q == StIdle && grant_if && perf_if_grants != '1) begin
        perf_if_grants <= perf_if_grants + 1;
      end
      if (state_q == StIdle && grant_dm && perf_dm_grants != '1) begin
        perf_dm_grants <= perf_dm_grants + 1;
      end
      if ((stall_if || stall_mem) && perf_wait_cycles != '1) begin
        perf_wait_cycles <= perf_wait_cycles + 1;
      end
    end
  end
`endif

endmodule
